dtu_transfer_engine: RTL and testbench

- Responder end of the DTU request interface driven by the LU marshaller controller.
- Accepts single-cycle write and read requests and acknowledges each one.
- Queues requests and moves `dtu_size` words per request between the on-chip block RAMs and the external DDR memory port.
- Reports `dtu_done` while the request queue and the engine are both idle.

---
 rtl/dtu_transfer_engine_if.sv | 32 +++
 rtl/dtu_transfer_engine.sv | 278 +++++++++++++++++++++++++++
 tb/tb_dtu_transfer_engine.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dtu_transfer_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : dtu_transfer_engine_if
// Brief    : DTU request/acknowledge bundle between the marshaller and engine.
// Revision : 1.0 - initial release
// ============================================================================
interface dtu_transfer_engine_if #(
    parameter int DDRSIZEWIDTH = 24,
    parameter int RAMSIZEWIDTH = 7,
    parameter int BLOCKWIDTH   = 6
);
    logic                    dtu_write_req;
    logic                    dtu_read_req;
    logic [DDRSIZEWIDTH-1:0] dtu_mem_addr;
    logic [RAMSIZEWIDTH-1:0] dtu_ram_addr;
    logic [BLOCKWIDTH-1:0]   dtu_size;
    logic                    left_sel;
    logic                    dtu_ack;
    logic                    dtu_done;
    logic                    dtu_error;

    modport master (
        output dtu_write_req, dtu_read_req, dtu_mem_addr, dtu_ram_addr, dtu_size, left_sel,
        input  dtu_ack, dtu_done, dtu_error
    );

    modport slave (
        input  dtu_write_req, dtu_read_req, dtu_mem_addr, dtu_ram_addr, dtu_size, left_sel,
        output dtu_ack, dtu_done, dtu_error
    );
endinterface
`default_nettype wire

// File: rtl/dtu_transfer_engine.sv
`default_nettype none
// ============================================================================
// Module   : dtu_transfer_engine
// Brief    : Queues DTU requests and moves word blocks between RAM and DDR.
//            Optional word counter on perf_words enabled by DTU_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dtu_transfer_engine #(
    parameter int DDRSIZEWIDTH = 24,
    parameter int RAMSIZEWIDTH = 7,
    parameter int BLOCKWIDTH   = 6,
    parameter int DATAWIDTH    = 256,
    parameter int FIFODEPTH    = 4,
    parameter int FIFODEPTHLOG = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    dtu_transfer_engine_if.slave    dtu,
    output logic [RAMSIZEWIDTH-1:0] ram_addr,
    output logic                    ram_we,
    output logic                    ram_left_sel,
    output logic [DATAWIDTH-1:0]    ram_wdata,
    input  logic [DATAWIDTH-1:0]    ram_rdata,
    output logic                    mem_cmd_valid,
    input  logic                    mem_cmd_ready,
    output logic                    mem_cmd_write,
    output logic [DDRSIZEWIDTH-1:0] mem_cmd_addr,
    output logic [BLOCKWIDTH-1:0]   mem_cmd_len,
    output logic [DATAWIDTH-1:0]    mem_wdata,
    output logic                    mem_wvalid,
    input  logic                    mem_wready,
    input  logic [DATAWIDTH-1:0]    mem_rdata,
    input  logic                    mem_rvalid,
    output logic [31:0]             perf_words
);

    typedef struct packed {
        logic                    write;
        logic [DDRSIZEWIDTH-1:0] mem_addr;
        logic [RAMSIZEWIDTH-1:0] ram_addr;
        logic [BLOCKWIDTH-1:0]   size;
        logic                    left_sel;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CMD      = 3'd1,
        S_WR_FETCH = 3'd2,
        S_WR_SEND  = 3'd3,
        S_RD_DATA  = 3'd4,
        S_FINISH   = 3'd5
    } state_t;

    // ---------------- request capture ----------------
    logic   w_req_any;
    entry_t w_req_entry;
    entry_t r_hold;
    logic   r_hold_valid;
    logic   r_ack;
    logic   r_error;
    logic   r_done;

    assign w_req_any = dtu.dtu_write_req | dtu.dtu_read_req;

    // A simultaneous write+read keeps the write; the read is flagged and lost.
    always_comb begin
        w_req_entry.write    = dtu.dtu_write_req;
        w_req_entry.mem_addr = dtu.dtu_mem_addr;
        w_req_entry.ram_addr = dtu.dtu_ram_addr;
        w_req_entry.size     = dtu.dtu_size;
        w_req_entry.left_sel = dtu.left_sel;
    end

    // ---------------- request queue ----------------
    entry_t                  q_mem [FIFODEPTH];
    logic [FIFODEPTHLOG:0]   r_wr_ptr;
    logic [FIFODEPTHLOG:0]   r_rd_ptr;
    logic                    w_q_full;
    logic                    w_q_empty;
    logic                    w_move;
    logic                    w_push;
    logic                    w_pop;

    assign w_q_empty = (r_wr_ptr == r_rd_ptr);
    assign w_q_full  = (r_wr_ptr[FIFODEPTHLOG] != r_rd_ptr[FIFODEPTHLOG]) &&
                       (r_wr_ptr[FIFODEPTHLOG-1:0] == r_rd_ptr[FIFODEPTHLOG-1:0]);
    // Zero-length requests leave the holding register even when the queue is full.
    assign w_move    = r_hold_valid && (!w_q_full || (r_hold.size == '0));
    assign w_push    = w_move && (r_hold.size != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
            r_hold       <= '0;
            r_ack        <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_ack <= w_move;
            if (w_move) begin
                r_hold_valid <= 1'b0;
            end
            if (w_req_any) begin
                if (r_hold_valid) begin
                    r_error <= 1'b1;
                end else begin
                    r_hold_valid <= 1'b1;
                    r_hold       <= w_req_entry;
                end
                if (dtu.dtu_write_req && dtu.dtu_read_req) begin
                    r_error <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            q_mem[r_wr_ptr[FIFODEPTHLOG-1:0]] <= r_hold;
        end
    end

    // ---------------- transfer engine ----------------
    state_t                  r_state;
    state_t                  w_state_next;
    entry_t                  r_entry;
    logic [BLOCKWIDTH-1:0]   r_k;
    logic [BLOCKWIDTH-1:0]   w_k_next;
    logic [BLOCKWIDTH-1:0]   w_k_inc;
    logic [RAMSIZEWIDTH-1:0] r_ram_addr;
    logic [RAMSIZEWIDTH-1:0] w_ram_addr_next;
    logic                    r_ram_we;
    logic                    w_ram_we_next;
    logic [DATAWIDTH-1:0]    r_ram_wdata;
    logic [DATAWIDTH-1:0]    w_ram_wdata_next;
    logic                    r_ram_left_sel;
    logic                    w_ram_left_next;

    assign w_k_inc = r_k + BLOCKWIDTH'(1);

    always_comb begin
        w_state_next     = r_state;
        w_pop            = 1'b0;
        w_k_next         = r_k;
        w_ram_addr_next  = r_ram_addr;
        w_ram_we_next    = 1'b0;
        w_ram_wdata_next = r_ram_wdata;
        w_ram_left_next  = r_ram_left_sel;
        case (r_state)
            S_IDLE: begin
                if (!w_q_empty) begin
                    w_pop        = 1'b1;
                    w_k_next     = '0;
                    w_state_next = S_CMD;
                end
            end
            S_CMD: begin
                if (mem_cmd_ready) begin
                    if (r_entry.write) begin
                        w_ram_addr_next = r_entry.ram_addr;
                        w_state_next    = S_WR_FETCH;
                    end else begin
                        w_state_next    = S_RD_DATA;
                    end
                end
            end
            S_WR_FETCH: begin
                w_state_next = S_WR_SEND;
            end
            // ram_addr is held here so ram_rdata stays stable while stalled.
            S_WR_SEND: begin
                if (mem_wready) begin
                    w_k_next = w_k_inc;
                    if (w_k_inc == r_entry.size) begin
                        w_state_next = S_FINISH;
                    end else begin
                        w_ram_addr_next = r_ram_addr + RAMSIZEWIDTH'(1);
                        w_state_next    = S_WR_FETCH;
                    end
                end
            end
            S_RD_DATA: begin
                if (mem_rvalid) begin
                    w_ram_we_next    = 1'b1;
                    w_ram_addr_next  = r_entry.ram_addr + RAMSIZEWIDTH'(r_k);
                    w_ram_wdata_next = mem_rdata;
                    w_ram_left_next  = r_entry.left_sel;
                    w_k_next         = w_k_inc;
                    if (w_k_inc == r_entry.size) begin
                        w_state_next = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_entry        <= '0;
            r_k            <= '0;
            r_ram_addr     <= '0;
            r_ram_we       <= 1'b0;
            r_ram_wdata    <= '0;
            r_ram_left_sel <= 1'b0;
            r_done         <= 1'b1;
        end else begin
            r_state        <= w_state_next;
            if (w_pop) begin
                r_entry <= q_mem[r_rd_ptr[FIFODEPTHLOG-1:0]];
            end
            r_k            <= w_k_next;
            r_ram_addr     <= w_ram_addr_next;
            r_ram_we       <= w_ram_we_next;
            r_ram_wdata    <= w_ram_wdata_next;
            r_ram_left_sel <= w_ram_left_next;
            // Looks at the next state so done rises right after FINISH.
            r_done         <= (w_state_next == S_IDLE) && w_q_empty && !r_hold_valid && !w_req_any;
        end
    end

    assign dtu.dtu_ack   = r_ack;
    assign dtu.dtu_done  = r_done;
    assign dtu.dtu_error = r_error;

    assign ram_addr      = r_ram_addr;
    assign ram_we        = r_ram_we;
    assign ram_left_sel  = r_ram_left_sel;
    assign ram_wdata     = r_ram_wdata;

    assign mem_cmd_valid = (r_state == S_CMD);
    assign mem_cmd_write = r_entry.write;
    assign mem_cmd_addr  = r_entry.mem_addr;
    assign mem_cmd_len   = r_entry.size;
    assign mem_wvalid    = (r_state == S_WR_SEND);
    assign mem_wdata     = mem_wvalid ? ram_rdata : '0;

`ifdef DTU_PERF_CNT_EN
    logic        w_beat;
    logic [31:0] r_perf_words;

    assign w_beat = ((r_state == S_WR_SEND) && mem_wready) ||
                    ((r_state == S_RD_DATA) && mem_rvalid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_words <= '0;
        end else if (w_beat && (r_perf_words != '1)) begin
            r_perf_words <= r_perf_words + 32'd1;
        end
    end

    assign perf_words = r_perf_words;
`else
    assign perf_words = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dtu_transfer_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_dtu_transfer_engine
// Brief    : Directed self-checking bench for dtu_transfer_engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dtu_transfer_engine;

`ifdef DTU_PERF_CNT_EN
    localparam bit c_perf_on = 1'b1;
`else
    localparam bit c_perf_on = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [6:0]   ram_addr;
    logic         ram_we;
    logic         ram_left_sel;
    logic [255:0] ram_wdata;
    logic [255:0] ram_rdata;
    logic         mem_cmd_valid;
    logic         mem_cmd_ready;
    logic         mem_cmd_write;
    logic [23:0]  mem_cmd_addr;
    logic [5:0]   mem_cmd_len;
    logic [255:0] mem_wdata;
    logic         mem_wvalid;
    logic         mem_wready;
    logic [255:0] mem_rdata;
    logic         mem_rvalid;
    logic [31:0]  perf_words;

    dtu_transfer_engine_if #(.DDRSIZEWIDTH(24), .RAMSIZEWIDTH(7), .BLOCKWIDTH(6)) dtu_bus ();

    dtu_transfer_engine #(
        .DDRSIZEWIDTH(24), .RAMSIZEWIDTH(7), .BLOCKWIDTH(6),
        .DATAWIDTH(256), .FIFODEPTH(4), .FIFODEPTHLOG(2)
    ) dut (
        .clk(clk), .rst(rst), .dtu(dtu_bus),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_left_sel(ram_left_sel),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_write(mem_cmd_write), .mem_cmd_addr(mem_cmd_addr), .mem_cmd_len(mem_cmd_len),
        .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .perf_words(perf_words)
    );

    int n_compared   = 0;
    int n_mismatched = 0;
    int exp_perf     = 0;

    logic [255:0] ram_mem [128];
    logic [30:0]  cmd_log   [$];
    logic [255:0] wbeat_log [$];
    logic [263:0] ramw_log  [$];

    int rd_left  = 0;
    int rd_addr  = 0;
    bit rd_phase = 1'b0;
    bit rd_gap   = 1'b0;

    function automatic logic [255:0] ram_word(input int a);
        logic [31:0] t;
        t = 32'hA500_0000 + a;
        return {8{t}};
    endfunction

    function automatic logic [255:0] ddr_word(input int a);
        logic [31:0] t;
        t = 32'hD000_0000 ^ a;
        return {8{t}};
    endfunction

    task automatic check_value(input string tag, input logic [263:0] obs, input logic [263:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int i = 0; i < 128; i++) ram_mem[i] = ram_word(i);
    end

    always @(posedge clk) ram_rdata <= ram_mem[ram_addr];

    always @(negedge clk) begin
        if (mem_cmd_valid && mem_cmd_ready) cmd_log.push_back({mem_cmd_write, mem_cmd_addr, mem_cmd_len});
        if (mem_wvalid && mem_wready)       wbeat_log.push_back(mem_wdata);
        if (ram_we)                         ramw_log.push_back({ram_left_sel, ram_addr, ram_wdata});
    end

    // DDR read responder; rd_gap gives a 1-on/1-off beat pattern.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_rvalid = 1'b0;
            if (rd_left > 0) begin
                if (!rd_phase) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = ddr_word(rd_addr);
                    rd_addr++;
                    rd_left--;
                end
                if (rd_gap) rd_phase = ~rd_phase;
            end
            if (mem_cmd_valid && mem_cmd_ready && !mem_cmd_write) begin
                rd_left  = int'(mem_cmd_len);
                rd_addr  = int'(mem_cmd_addr);
                rd_phase = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic rd, input logic [23:0] ma,
                         input logic [6:0] ra, input logic [5:0] sz, input logic ls);
        dtu_bus.dtu_write_req = wr;
        dtu_bus.dtu_read_req  = rd;
        dtu_bus.dtu_mem_addr  = ma;
        dtu_bus.dtu_ram_addr  = ra;
        dtu_bus.dtu_size      = sz;
        dtu_bus.left_sel      = ls;
        tick;
        dtu_bus.dtu_write_req = 1'b0;
        dtu_bus.dtu_read_req  = 1'b0;
    endtask

    task automatic wait_ack(input int lim, output int n);
        n = 0;
        while (!dtu_bus.dtu_ack && n < lim) begin
            tick;
            n++;
        end
    endtask

    task automatic wait_done(input string tag, input int lim);
        int n;
        n = 0;
        while (!dtu_bus.dtu_done && n < lim) begin
            tick;
            n++;
        end
        check_value(tag, dtu_bus.dtu_done, 1);
    endtask

    initial begin
        int n, c0, w0, r0, low, acks;
        logic [6:0] ra;
        rst = 1'b1;
        mem_cmd_ready = 1'b1;
        mem_wready    = 1'b1;
        dtu_bus.dtu_write_req = 1'b0;
        dtu_bus.dtu_read_req  = 1'b0;
        dtu_bus.dtu_mem_addr  = '0;
        dtu_bus.dtu_ram_addr  = '0;
        dtu_bus.dtu_size      = '0;
        dtu_bus.left_sel      = 1'b0;
        repeat (3) tick;
        check_value("rst_done",      dtu_bus.dtu_done, 1);
        check_value("rst_ack",       dtu_bus.dtu_ack, 0);
        check_value("rst_error",     dtu_bus.dtu_error, 0);
        check_value("rst_cmd_valid", mem_cmd_valid, 0);
        check_value("rst_wvalid",    mem_wvalid, 0);
        check_value("rst_ram_we",    ram_we, 0);
        check_value("rst_perf",      perf_words, 0);
        rst = 1'b0;
        tick;

        // Write 4 words RAM[0..3] -> DDR 0x100
        c0 = cmd_log.size(); w0 = wbeat_log.size();
        issue(1'b1, 1'b0, 24'h000100, 7'd0, 6'd4, 1'b0);
        check_value("t1_done_low", dtu_bus.dtu_done, 0);
        wait_ack(10, n);
        check_value("t1_ack_latency", n, 1);
        tick;
        check_value("t1_ack_pulse", dtu_bus.dtu_ack, 0);
        wait_done("t1_done", 100);
        check_value("t1_cmd_count", cmd_log.size() - c0, 1);
        if (cmd_log.size() > c0) check_value("t1_cmd", cmd_log[c0], {1'b1, 24'h000100, 6'd4});
        check_value("t1_beat_count", wbeat_log.size() - w0, 4);
        for (int i = 0; i < 4; i++)
            if (wbeat_log.size() > w0 + i) check_value($sformatf("t1_wdata%0d", i), wbeat_log[w0 + i], ram_word(i));
        exp_perf += 4;

        // Read 4 words DDR 0x40 -> left RAM[8..11], gapped beats
        rd_gap = 1'b1;
        r0 = ramw_log.size();
        issue(1'b0, 1'b1, 24'h000040, 7'd8, 6'd4, 1'b1);
        wait_ack(10, n);
        check_value("t2_ack_latency", n, 1);
        wait_done("t2_done", 100);
        check_value("t2_ramw_count", ramw_log.size() - r0, 4);
        for (int i = 0; i < 4; i++) begin
            ra = 7'(8 + i);
            if (ramw_log.size() > r0 + i)
                check_value($sformatf("t2_ramw%0d", i), ramw_log[r0 + i], {1'b1, ra, ddr_word(32'h40 + i)});
        end
        exp_perf += 4;
        check_value("t2_perf", perf_words, c_perf_on ? exp_perf : 0);
        rd_gap = 1'b0;

        // Six requests against a stalled command port
        mem_cmd_ready = 1'b0;
        c0 = cmd_log.size(); w0 = wbeat_log.size(); r0 = ramw_log.size();
        for (int i = 0; i < 6; i++) begin
            issue(i % 2 == 0, i % 2 == 1, 24'(32'h1000 + i * 16), 7'(i * 4), 6'd2, 1'b0);
            if (i < 5) begin
                wait_ack(10, n);
                check_value($sformatf("t3_ack%0d", i), n, 1);
            end
        end
        acks = 0;
        repeat (8) begin
            if (dtu_bus.dtu_ack) acks++;
            tick;
        end
        check_value("t3_ack6_held", acks, 0);
        mem_cmd_ready = 1'b1;
        wait_ack(60, n);
        check_value("t3_ack6_late", dtu_bus.dtu_ack, 1);
        wait_done("t3_done", 300);
        check_value("t3_cmd_count", cmd_log.size() - c0, 6);
        for (int i = 0; i < 6; i++)
            if (cmd_log.size() > c0 + i)
                check_value($sformatf("t3_cmd%0d", i), cmd_log[c0 + i],
                            {(i % 2 == 0) ? 1'b1 : 1'b0, 24'(32'h1000 + i * 16), 6'd2});
        check_value("t3_wbeats", wbeat_log.size() - w0, 6);
        check_value("t3_ramw", ramw_log.size() - r0, 6);
        if (wbeat_log.size() > w0 + 1) check_value("t3_wdata_q0", wbeat_log[w0 + 1], ram_word(1));
        check_value("t3_error", dtu_bus.dtu_error, 0);
        exp_perf += 12;
        check_value("t3_perf", perf_words, c_perf_on ? exp_perf : 0);

        // Zero-length request
        c0 = cmd_log.size();
        issue(1'b1, 1'b0, 24'h000300, 7'd0, 6'd0, 1'b0);
        low = 0; acks = 0;
        while (!dtu_bus.dtu_done && low < 10) begin
            low++;
            tick;
            if (dtu_bus.dtu_ack) acks++;
        end
        check_value("t4_done_low_len", (low >= 1 && low <= 2), 1);
        check_value("t4_ack_count", acks, 1);
        repeat (4) tick;
        check_value("t4_no_cmd", cmd_log.size() - c0, 0);

        // Write and read together: write wins, error sticks
        c0 = cmd_log.size(); r0 = ramw_log.size();
        issue(1'b1, 1'b1, 24'h000200, 7'd16, 6'd2, 1'b0);
        wait_ack(10, n);
        check_value("t5_ack_latency", n, 1);
        wait_done("t5_done", 100);
        check_value("t5_cmd_count", cmd_log.size() - c0, 1);
        if (cmd_log.size() > c0) check_value("t5_cmd", cmd_log[c0], {1'b1, 24'h000200, 6'd2});
        check_value("t5_no_ramw", ramw_log.size() - r0, 0);
        check_value("t5_error", dtu_bus.dtu_error, 1);
        repeat (3) tick;
        check_value("t5_error_sticky", dtu_bus.dtu_error, 1);

        // Reset during the second word of a gapped 4-word read
        rd_gap = 1'b1;
        r0 = ramw_log.size();
        issue(1'b0, 1'b1, 24'h000080, 7'd32, 6'd4, 1'b0);
        wait_ack(10, n);
        n = 0;
        while (ramw_log.size() == r0 && n < 40) begin
            tick;
            n++;
        end
        check_value("t6_first_word", ramw_log.size() - r0, 1);
        rst = 1'b1;
        tick;
        check_value("t6_cmd_valid", mem_cmd_valid, 0);
        check_value("t6_wvalid",    mem_wvalid, 0);
        check_value("t6_ram_we",    ram_we, 0);
        check_value("t6_ram_addr",  ram_addr, 0);
        check_value("t6_ram_wdata", ram_wdata, 0);
        check_value("t6_left_sel",  ram_left_sel, 0);
        check_value("t6_cmd_addr",  mem_cmd_addr, 0);
        check_value("t6_cmd_len",   mem_cmd_len, 0);
        check_value("t6_ack",       dtu_bus.dtu_ack, 0);
        check_value("t6_error",     dtu_bus.dtu_error, 0);
        check_value("t6_done",      dtu_bus.dtu_done, 1);
        check_value("t6_perf",      perf_words, 0);
        r0 = ramw_log.size();
        rst = 1'b0;
        repeat (10) tick;
        check_value("t6_late_beats_ignored", ramw_log.size() - r0, 0);
        check_value("t6_idle_done", dtu_bus.dtu_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
